// File: rtl/layer3_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// layer3_pkg : shared constants and state encoding for layer3_argmax
// Rev 1.0
// ---------------------------------------------------------------------------
package layer3_pkg;

  localparam int NUM_IN = 16;
  localparam int WIDTH  = 16;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/argmax_cmp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// argmax_cmp : signed "candidate > best" compare with value/index select
// Rev 1.0
// ---------------------------------------------------------------------------
module argmax_cmp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]              cand_val,
  input  logic [layer3_pkg::IDX_W-1:0]  cand_idx,
  input  logic [WIDTH-1:0]              best_val,
  input  logic [layer3_pkg::IDX_W-1:0]  best_idx,
  output logic [WIDTH-1:0]              sel_val,
  output logic [layer3_pkg::IDX_W-1:0]  sel_idx
);

  logic gt;

  // Strictly greater keeps the earlier (lower) index on ties.
  assign gt      = $signed(cand_val) > $signed(best_val);
  assign sel_val = gt ? cand_val : best_val;
  assign sel_idx = gt ? cand_idx : best_idx;

endmodule
`default_nettype wire

// File: rtl/layer3_argmax.sv
`default_nettype none
// ---------------------------------------------------------------------------
// layer3_argmax : sequential argmax over 16 snapshotted signed activations
// Rev 1.0
// ---------------------------------------------------------------------------
module layer3_argmax #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [WIDTH-1:0]                 N0x,
  input  logic [WIDTH-1:0]                 N1x,
  input  logic [WIDTH-1:0]                 N2x,
  input  logic [WIDTH-1:0]                 N3x,
  input  logic [WIDTH-1:0]                 N4x,
  input  logic [WIDTH-1:0]                 N5x,
  input  logic [WIDTH-1:0]                 N6x,
  input  logic [WIDTH-1:0]                 N7x,
  input  logic [WIDTH-1:0]                 N8x,
  input  logic [WIDTH-1:0]                 N9x,
  input  logic [WIDTH-1:0]                 N10x,
  input  logic [WIDTH-1:0]                 N11x,
  input  logic [WIDTH-1:0]                 N12x,
  input  logic [WIDTH-1:0]                 N13x,
  input  logic [WIDTH-1:0]                 N14x,
  input  logic [WIDTH-1:0]                 N15x,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [layer3_pkg::IDX_W-1:0]     class_idx,
  output logic [WIDTH-1:0]                 max_val
);

  import layer3_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  state_t            state;
  logic [WIDTH-1:0]  in_vec [NUM_IN];
  logic [WIDTH-1:0]  snap   [NUM_IN];
  logic [WIDTH-1:0]  best;
  logic [IDX_W-1:0]  best_idx;
  logic [IDX_W-1:0]  cnt;
  logic [WIDTH-1:0]  sel_val;
  logic [IDX_W-1:0]  sel_idx;

  assign in_vec[0]  = N0x;
  assign in_vec[1]  = N1x;
  assign in_vec[2]  = N2x;
  assign in_vec[3]  = N3x;
  assign in_vec[4]  = N4x;
  assign in_vec[5]  = N5x;
  assign in_vec[6]  = N6x;
  assign in_vec[7]  = N7x;
  assign in_vec[8]  = N8x;
  assign in_vec[9]  = N9x;
  assign in_vec[10] = N10x;
  assign in_vec[11] = N11x;
  assign in_vec[12] = N12x;
  assign in_vec[13] = N13x;
  assign in_vec[14] = N14x;
  assign in_vec[15] = N15x;

  argmax_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .cand_val (snap[cnt]),
    .cand_idx (cnt),
    .best_val (best),
    .best_idx (best_idx),
    .sel_val  (sel_val),
    .sel_idx  (sel_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_idx <= '0;
      max_val   <= '0;
      cnt       <= '0;
      best      <= '0;
      best_idx  <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        snap[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_IN; i++) begin
              snap[i] <= in_vec[i];
            end
            best     <= in_vec[0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
            state    <= SCAN;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          best     <= sel_val;
          best_idx <= sel_idx;
          // Leave before incrementing so cnt never wraps past the last node.
          if (cnt == LAST_IDX) begin
            state <= DONE;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        DONE: begin
          class_idx <= best_idx;
          max_val   <= best;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
